// File: rtl/imem_loader.sv
// Byte-stream loader for the cpu instruction memory: packs 4 LE bytes per word, writes word k to address 4*k.
// 5 cycles/word minimum (4 bytes + 1 write); byte_ready=1 only in LOAD; cpu held in reset until DONE.
module imem_loader #(
   parameter int MAX_WORDS = 1024,
   parameter int CNT_WIDTH = 11
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] length_words,
   input  logic                 byte_valid,
   input  logic [7:0]           byte_data,
   output logic                 byte_ready,
   output logic                 mem_we,
   output logic [31:0]          mem_addr,
   output logic [31:0]          mem_wdata,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic                 cpu_reset_n
);

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   state_t               state, state_nx;
   logic [CNT_WIDTH-1:0] count, count_nx;
   logic [CNT_WIDTH-1:0] word_idx, word_idx_nx;
   logic [1:0]           byte_idx, byte_idx_nx;
   logic [31:0]          word, word_nx;
   logic                 err_nx;

   always_comb begin
      state_nx    = state;
      count_nx    = count;
      word_idx_nx = word_idx;
      byte_idx_nx = byte_idx;
      word_nx     = word;
      err_nx      = err;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               if (length_words == '0) begin
                  state_nx = DONE;
               end else if (length_words <= CNT_WIDTH'(MAX_WORDS)) begin
                  count_nx    = length_words;
                  word_idx_nx = '0;
                  byte_idx_nx = '0;
                  word_nx     = '0;
                  err_nx      = 1'b0;
                  state_nx    = LOAD;
               end else begin
                  // oversized program: flag it, keep the current state
                  err_nx = 1'b1;
               end
            end
         end
         LOAD: begin
            if (byte_valid) begin
               word_nx[{byte_idx, 3'b000} +: 8] = byte_data;
               byte_idx_nx = byte_idx + 2'd1;
               if (byte_idx == 2'd3) begin
                  state_nx = WRITE;
               end
            end
         end
         WRITE: begin
            // stop before word_idx reaches count so the address never passes the last slot
            if (word_idx + CNT_WIDTH'(1) == count) begin
               state_nx = DONE;
            end else begin
               word_idx_nx = word_idx + CNT_WIDTH'(1);
               state_nx    = LOAD;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         count       <= '0;
         word_idx    <= '0;
         byte_idx    <= '0;
         word        <= '0;
         err         <= 1'b0;
         byte_ready  <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cpu_reset_n <= 1'b0;
      end else begin
         state       <= state_nx;
         count       <= count_nx;
         word_idx    <= word_idx_nx;
         byte_idx    <= byte_idx_nx;
         word        <= word_nx;
         err         <= err_nx;
         byte_ready  <= (state_nx == LOAD);
         mem_we      <= (state_nx == WRITE);
         busy        <= (state_nx == LOAD) || (state_nx == WRITE);
         done        <= (state_nx == DONE);
         cpu_reset_n <= (state_nx == DONE);
         if (state_nx == WRITE) begin
            mem_addr  <= 32'(word_idx) << 2;
            mem_wdata <= word_nx;
         end
      end
   end

endmodule
